// File: rtl/len_burst_tx_pkg.sv
// Shared definitions for the length-prefixed val/rdy burst stream:
// default field widths and the transmitter/receiver state encodings.
package len_burst_tx_pkg;

    localparam int unsigned LEN_W_DEFAULT  = 8;
    localparam int unsigned DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_HDR,
        TX_BODY
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_BODY
    } rx_state_t;

endpackage

// File: rtl/len_burst_tx.sv
// Burst transmitter: one header beat carrying the length, then that many
// payload beats counting up from the seed. Back-to-back commands add no bubble.
module len_burst_tx
    import len_burst_tx_pkg::*;
#(
    parameter int unsigned LEN_W  = LEN_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_val,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_seed,
    output logic              cmd_rdy,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_is_hdr,
    output logic              out_last,
    output logic              busy
);

    if (DATA_W < LEN_W) begin : g_bad_width
        $error("len_burst_tx: DATA_W must be >= LEN_W");
    end

    tx_state_t         state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              burst_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            seed_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            seed_q  <= seed_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        seed_d     = seed_q;
        out_val    = 1'b0;
        out_is_hdr = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;

        // Outputs depend only on registered state, so they hold while stalled.
        case (state_q)
            TX_HDR: begin
                out_val    = 1'b1;
                out_is_hdr = 1'b1;
                out_data   = DATA_W'(len_q);
                out_last   = (len_q == '0);
            end
            TX_BODY: begin
                out_val  = 1'b1;
                out_data = seed_q + DATA_W'(idx_q);
                out_last = (idx_q == len_q - LEN_W'(1));
            end
            default: ;
        endcase

        burst_done = out_val & out_rdy & out_last;
        cmd_rdy    = (state_q == TX_IDLE) | burst_done;
        busy       = (state_q != TX_IDLE);

        case (state_q)
            TX_HDR: begin
                if (out_rdy && !out_last) begin
                    state_d = TX_BODY;
                    idx_d   = '0;
                end
            end
            TX_BODY: begin
                if (out_rdy && !out_last) begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            default: ;
        endcase

        // Completion and idle acceptance share one path, giving zero-bubble chaining.
        if (cmd_rdy) begin
            if (cmd_val) begin
                state_d = TX_HDR;
                len_d   = cmd_len;
                seed_d  = cmd_seed;
                idx_d   = '0;
            end else if (burst_done) begin
                state_d = TX_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_len_burst_tx.sv
// Directed + randomized bench for len_burst_tx, checked against a beat-list
// model expanded from each accepted command.
module tb_len_burst_tx;

    localparam int unsigned LEN_W  = 8;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_val = 1'b0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DATA_W-1:0] cmd_seed = '0;
    logic              cmd_rdy;
    logic              out_val;
    logic              out_rdy = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_is_hdr;
    logic              out_last;
    logic              busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int unsigned len;
        logic [31:0] seed;
    } cmd_t;

    typedef struct {
        logic [31:0] data;
        logic        hdr;
        logic        last;
    } beat_t;

    cmd_t  cq[$];
    beat_t eq[$];

    len_burst_tx #(.LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_val    (cmd_val),
        .cmd_len    (cmd_len),
        .cmd_seed   (cmd_seed),
        .cmd_rdy    (cmd_rdy),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .out_is_hdr (out_is_hdr),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A burst is its header (data = length) followed by seed, seed+1, ...
    function automatic void expand(input cmd_t c);
        beat_t b;
        b.data = 32'(c.len);
        b.hdr  = 1'b1;
        b.last = (c.len == 0);
        eq.push_back(b);
        for (int unsigned i = 0; i < c.len; i++) begin
            b.data = c.seed + i;
            b.hdr  = 1'b0;
            b.last = (i == c.len - 1);
            eq.push_back(b);
        end
    endfunction

    task automatic push_cmd(input int unsigned len, input logic [31:0] seed);
        cmd_t c;
        c.len  = len;
        c.seed = seed;
        cq.push_back(c);
    endtask

    task automatic run(input int unsigned rdy_pct, input int unsigned budget, input string tag);
        int unsigned cyc = 0;
        bit in_burst;
        bit exp_rdy;
        bit fire;
        while ((cq.size() != 0 || eq.size() != 0) && cyc < budget) begin
            if (cq.size() != 0) begin
                cmd_val  = 1'b1;
                cmd_len  = LEN_W'(cq[0].len);
                cmd_seed = cq[0].seed;
            end else begin
                cmd_val  = 1'b0;
                cmd_len  = LEN_W'($urandom);
                cmd_seed = $urandom;
            end
            out_rdy = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            in_burst = (eq.size() != 0);
            exp_rdy  = 1'b1;
            if (in_burst) exp_rdy = out_rdy && eq[0].last;
            chk({tag, ".val"},  32'(out_val), 32'(in_burst));
            chk({tag, ".busy"}, 32'(busy),    32'(in_burst));
            chk({tag, ".crdy"}, 32'(cmd_rdy), 32'(exp_rdy));
            if (in_burst) begin
                chk({tag, ".data"}, out_data,         eq[0].data);
                chk({tag, ".hdr"},  32'(out_is_hdr),  32'(eq[0].hdr));
                chk({tag, ".last"}, 32'(out_last),    32'(eq[0].last));
            end
            fire = cmd_val && exp_rdy;
            @(posedge clk);
            if (in_burst && out_rdy) void'(eq.pop_front());
            if (fire) expand(cq.pop_front());
            #1;
            cyc++;
        end
        cmd_val = 1'b0;
        chk({tag, ".drain"}, 32'(eq.size() + cq.size()), 32'd0);
        eq.delete();
        cq.delete();
        @(negedge clk);
        chk({tag, ".idle_val"},  32'(out_val), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy),    32'd0);
        chk({tag, ".idle_crdy"}, 32'(cmd_rdy), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("reset.val",  32'(out_val),    32'd0);
        chk("reset.hdr",  32'(out_is_hdr), 32'd0);
        chk("reset.last", 32'(out_last),   32'd0);
        chk("reset.data", out_data,        32'd0);
        chk("reset.busy", 32'(busy),       32'd0);
        chk("reset.crdy", 32'(cmd_rdy),    32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        push_cmd(3, 32'h10);
        run(100, 20, "basic");

        push_cmd(0, 32'hAA);
        run(100, 20, "zero");

        push_cmd(4, $urandom);
        run(50, 200, "bp");

        push_cmd(1, 32'h20);
        push_cmd(2, 32'h40);
        run(100, 20, "b2b");

        push_cmd(255, 32'hFFFF_FFFE);
        run(100, 400, "max");

        // Abandon a burst by asserting reset during its third payload beat.
        cmd_val  = 1'b1;
        cmd_len  = LEN_W'(5);
        cmd_seed = 32'h100;
        out_rdy  = 1'b1;
        @(posedge clk);
        #1;
        cmd_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.pre_val",  32'(out_val), 32'd1);
        chk("rst.pre_data", out_data,     32'h102);
        rst_n = 1'b0;
        #1;
        chk("rst.val",  32'(out_val),    32'd0);
        chk("rst.busy", 32'(busy),       32'd0);
        chk("rst.data", out_data,        32'd0);
        chk("rst.last", 32'(out_last),   32'd0);
        chk("rst.crdy", 32'(cmd_rdy),    32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_cmd(2, 32'h300);
        run(100, 20, "after_rst");

        repeat (8) push_cmd($urandom_range(12), $urandom);
        run(60, 600, "rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
